core_fetch_queue: RTL
=====================

CORE_FETCH_QUEUE -- requirements
Module: core_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..8).
REQ-002 SHALL have parameter RESET_PC, default 8'h10, meaning fetch address after reset.
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port mode_i  input  2  fetch mode: 0 hold, 1 run, 2 single, 3 treated as 0.
REQ-006 SHALL have port redirect_i  input  1  flush queue and restart fetch at redirect_pc_i.
REQ-007 SHALL have port redirect_pc_i  input  8  new fetch address.
REQ-008 SHALL have port snoop_val_i  input  1  a store to instruction memory occurs this cycle.
REQ-009 SHALL have port snoop_addr_i  input  8  address of that store.
REQ-010 SHALL have port mem_addr_o  output  8  instruction memory read address.
REQ-011 SHALL have port mem_val_o  output  1  read request.
REQ-012 SHALL have port mem_rdy_i  input  1  read accepted; mem_rdata_i valid in the same cycle.
REQ-013 SHALL have port mem_rdata_i  input  16  instruction word.
REQ-014 SHALL have port out_val_o  output  1  head entry valid.
REQ-015 SHALL have port out_rdy_i  input  1  consumer takes head entry.
REQ-016 SHALL have port out_pc_o  output  8  PC of head entry.
REQ-017 SHALL have port out_instr_o  output  16  instruction of head entry.
REQ-018 SHALL have port fetch_pc_o  output  8  next address to fetch.
REQ-019 SHALL have port count_o  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-020 SHALL hold a circular buffer of DEPTH {pc[7:0], instr[15:0]} entries with read pointer, write pointer and count.
REQ-021 SHALL drive mem_addr_o = fetch_pc at all times.
REQ-022 SHALL assert mem_val_o only if ~redirect_i and count<DEPTH and (mode_i==1, or mode_i==2 with count==0).
REQ-023 SHALL, on mem_val_o && mem_rdy_i with no snoop hit (REQ-028), push {fetch_pc, mem_rdata_i} and set fetch_pc <= fetch_pc+1 mod 256 (8'hFF wraps to 8'h00).
REQ-024 SHALL hold mem_val_o and mem_addr_o stable while mem_rdy_i is low, unless redirect or snoop hit changes fetch_pc.
REQ-025 SHALL drive out_val_o = (count!=0) && ~redirect_i && ~(snoop hit on head entry); out_pc_o/out_instr_o come from head and are 0 when count==0.
REQ-026 SHALL pop the head on out_val_o && out_rdy_i; push and pop in one cycle leave count unchanged.
REQ-027 SHALL, on redirect_i (highest priority), set count to 0, reset both pointers to 0, set fetch_pc <= redirect_pc_i, and discard any push or pop that cycle.
REQ-028 SHALL, on snoop_val_i without redirect_i, compare snoop_addr_i with every valid entry's pc; the oldest match k SHALL drop entry k and all younger entries and set fetch_pc <= pc of k.
REQ-029 SHALL allow a pop in the same cycle as a snoop hit only if the head is older than k; the resulting count is the number of surviving entries minus the pop.
REQ-030 SHALL, with no entry match, suppress a push whose fetch_pc equals snoop_addr_i and leave fetch_pc unchanged, so the word is re-read next cycle.
REQ-031 SHALL continue draining the queue in mode 0; mode changes SHALL NOT flush.
REQ-032 SHALL drive count_o and fetch_pc_o as the registered values.

Reset
REQ-033 SHALL, while rst_i is high at a clock edge, set fetch_pc to RESET_PC, set count and both pointers to 0, and clear all entries; rst_i overrides redirect, snoop, push and pop.
REQ-034 SHALL hold outputs after reset at: out_val_o=0, mem_val_o=0 in mode 0, count_o=0, fetch_pc_o=8'h10.

Verification
REQ-035 SHALL pass this case: reset, mode 1, mem_rdy_i=1, memory[a]=a*3, out_rdy_i=0 -> 4 pushes of pc 10..13, then mem_val_o=0 and count_o=4; out_rdy_i=1 -> pc/instr pairs returned in order.
REQ-036 SHALL pass this case: fetch_pc=8'hFE, run -> entries pc FE, FF, 00, 01.
REQ-037 SHALL pass this case: queue holds 20..23, redirect_i with redirect_pc_i=8'h40 and out_rdy_i=1 -> no pop, next cycle count 0, mem_addr_o=40.
REQ-038 SHALL pass this case: queue holds 20..23, snoop_addr_i=22 with head pop -> pc 20 delivered, count 1 (pc 21), fetch_pc 22, and refetched word 22 carries the new data.
REQ-039 SHALL pass this case: mode 2 with out_rdy_i=0 -> exactly one entry fetched; after pop, exactly one more.
REQ-040 SHALL pass this case: mem_rdy_i low for 3 cycles mid-fill -> mem_addr_o stable and no push until rdy; rst_i mid-fill -> count 0, fetch_pc 10.

Source files
------------

// File: rtl/core_fetch_queue_if.sv
// Bundle of the fetch queue's control, memory-read and consumer signals.
// The queue itself connects through the slave modport; the driving environment uses master.
interface core_fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic [1:0]                   mode_i;
    logic                         redirect_i;
    logic [7:0]                   redirect_pc_i;
    logic                         snoop_val_i;
    logic [7:0]                   snoop_addr_i;
    logic [7:0]                   mem_addr_o;
    logic                         mem_val_o;
    logic                         mem_rdy_i;
    logic [15:0]                  mem_rdata_i;
    logic                         out_val_o;
    logic                         out_rdy_i;
    logic [7:0]                   out_pc_o;
    logic [15:0]                  out_instr_o;
    logic [7:0]                   fetch_pc_o;
    logic [$clog2(DEPTH+1)-1:0]   count_o;

    modport master (
        output mode_i, redirect_i, redirect_pc_i, snoop_val_i, snoop_addr_i,
        output mem_rdy_i, mem_rdata_i, out_rdy_i,
        input  mem_addr_o, mem_val_o, out_val_o, out_pc_o, out_instr_o,
        input  fetch_pc_o, count_o
    );

    modport slave (
        input  mode_i, redirect_i, redirect_pc_i, snoop_val_i, snoop_addr_i,
        input  mem_rdy_i, mem_rdata_i, out_rdy_i,
        output mem_addr_o, mem_val_o, out_val_o, out_pc_o, out_instr_o,
        output fetch_pc_o, count_o
    );
endinterface

// File: rtl/core_fetch_queue.sv
// Instruction prefetch queue: a circular buffer of {pc, instr} entries filled from
// instruction memory, with redirect flush and self-modifying-code snoop invalidation.
module core_fetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h10
) (
    input logic               clk_i,
    input logic               rst_i,
    core_fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [7:0]       pc_reg    [DEPTH];
    logic [15:0]      instr_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [7:0]       fetch_pc_reg;

    logic [DEPTH-1:0] age_match;
    logic             hit_any;
    logic [CNT_W-1:0] hit_age;
    logic [PTR_W-1:0] hit_slot;
    logic             snoop_hit;
    logic             head_hit;
    logic             addr_snooped;
    logic             mem_val;
    logic             push;
    logic             out_val;
    logic             pop;

    // age_match[gi] compares the gi-th oldest valid entry against the snooped store address
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] slot;
            assign slot          = rd_ptr_reg + PTR_W'(gi);
            assign age_match[gi] = (CNT_W'(gi) < count_reg) && (pc_reg[slot] == bus.snoop_addr_i);
        end
    endgenerate

    // Scan from youngest to oldest so the oldest matching entry wins
    always_comb begin
        hit_any  = 1'b0;
        hit_age  = '0;
        hit_slot = rd_ptr_reg;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (age_match[j]) begin
                hit_any  = 1'b1;
                hit_age  = CNT_W'(j);
                hit_slot = rd_ptr_reg + PTR_W'(j);
            end
        end
    end

    assign snoop_hit    = bus.snoop_val_i && !bus.redirect_i && hit_any;
    assign head_hit     = snoop_hit && (hit_age == '0);
    assign addr_snooped = bus.snoop_val_i && (fetch_pc_reg == bus.snoop_addr_i);
    assign mem_val      = !bus.redirect_i && (count_reg < CNT_W'(DEPTH)) &&
                          ((bus.mode_i == 2'd1) || ((bus.mode_i == 2'd2) && (count_reg == '0)));
    // A store to the word being fetched makes the returned data stale; re-read it next cycle
    assign push         = mem_val && bus.mem_rdy_i && !snoop_hit && !addr_snooped;
    assign out_val      = (count_reg != '0) && !bus.redirect_i && !head_hit;
    assign pop          = out_val && bus.out_rdy_i;

    assign bus.mem_addr_o  = fetch_pc_reg;
    assign bus.mem_val_o   = mem_val;
    assign bus.out_val_o   = out_val;
    assign bus.out_pc_o    = (count_reg != '0) ? pc_reg[rd_ptr_reg] : 8'h00;
    assign bus.out_instr_o = (count_reg != '0) ? instr_reg[rd_ptr_reg] : 16'h0000;
    assign bus.fetch_pc_o  = fetch_pc_reg;
    assign bus.count_o     = count_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            fetch_pc_reg <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                pc_reg[i]    <= 8'h00;
                instr_reg[i] <= 16'h0000;
            end
        end else if (bus.redirect_i) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            fetch_pc_reg <= bus.redirect_pc_i;
        end else if (snoop_hit) begin
            // Keep only entries older than the hit, then refetch from the hit's pc
            wr_ptr_reg   <= hit_slot;
            rd_ptr_reg   <= rd_ptr_reg + PTR_W'(pop);
            count_reg    <= hit_age - CNT_W'(pop);
            fetch_pc_reg <= pc_reg[hit_slot];
        end else begin
            if (push) begin
                pc_reg[wr_ptr_reg]    <= fetch_pc_reg;
                instr_reg[wr_ptr_reg] <= bus.mem_rdata_i;
                wr_ptr_reg            <= wr_ptr_reg + PTR_W'(1);
                fetch_pc_reg          <= fetch_pc_reg + 8'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule
